// File: rtl/lzd_pkg.sv
// rtl/lzd_pkg.sv - shared constants and width helper for the pipelined leading-zero detector
package lzd_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (((n - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lzd_tree.sv
// rtl/lzd_tree.sv - combinational recursive leading-zero detector; p is raw (all ones) when v=0
module lzd_tree #(
    parameter int W = 4
) (
    input  logic [W-1:0]         i_a,
    output logic [$clog2(W)-1:0] o_p,
    output logic                 o_v
);

    generate
        if (W == 2) begin : g_leaf
            assign o_v = |i_a;
            assign o_p = ~i_a[1];
        end else begin : g_node
            logic [$clog2(W)-2:0] w_pu;
            logic [$clog2(W)-2:0] w_pl;
            logic                 w_vu;
            logic                 w_vl;

            lzd_tree #(.W(W / 2)) u_hi (
                .i_a (i_a[W-1:W/2]),
                .o_p (w_pu),
                .o_v (w_vu)
            );

            lzd_tree #(.W(W / 2)) u_lo (
                .i_a (i_a[W/2-1:0]),
                .o_p (w_pl),
                .o_v (w_vl)
            );

            assign o_v = w_vu | w_vl;
            assign o_p = w_vu ? {1'b0, w_pu} : {1'b1, w_pl};
        end
    endgenerate

endmodule

// File: rtl/lzd_pipe.sv
// rtl/lzd_pipe.sv - 2-stage leading-zero detector with valid/ready and tag; LZD_NORM_EN adds norm output
module lzd_pipe
    import lzd_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  TAG_W = 4,
    localparam int PBITS = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PBITS-1:0] p,
    output logic             v,
    output logic [TAG_W-1:0] tag_out
`ifdef LZD_NORM_EN
    ,
    output logic [WIDTH-1:0] norm
`endif
);

    localparam int HW = WIDTH / 2;

    logic             w_stall;
    logic [PBITS-2:0] w_pu;
    logic [PBITS-2:0] w_pl;
    logic             w_vu;
    logic             w_vl;
    logic [PBITS-1:0] w_p;
    logic             w_v;

    logic             r_s1_valid;
    logic [PBITS-2:0] r_pu;
    logic [PBITS-2:0] r_pl;
    logic             r_vu;
    logic             r_vl;
    logic [TAG_W-1:0] r_tag1;

    logic             r_out_valid;
    logic [PBITS-1:0] r_p;
    logic             r_v;
    logic [TAG_W-1:0] r_tag_out;

    // A full output that is not being taken freezes the whole pipe.
    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_out_valid;
    assign p         = r_p;
    assign v         = r_v;
    assign tag_out   = r_tag_out;

    lzd_tree #(.W(HW)) u_tree_hi (
        .i_a (a[WIDTH-1:HW]),
        .o_p (w_pu),
        .o_v (w_vu)
    );

    lzd_tree #(.W(HW)) u_tree_lo (
        .i_a (a[HW-1:0]),
        .o_p (w_pl),
        .o_v (w_vl)
    );

    assign w_v = r_vu | r_vl;
    assign w_p = r_vu ? {1'b0, r_pu} : (r_vl ? {1'b1, r_pl} : '0);

`ifdef LZD_NORM_EN
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_norm;
    logic [WIDTH-1:0] w_norm;

    assign norm = r_norm;

    always_comb begin
        w_norm = r_a1;
        for (int i = 0; i < PBITS; i++) begin
            if (w_p[i]) begin
                w_norm = w_norm << (1 << i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_pu       <= '0;
            r_pl       <= '0;
            r_vu       <= 1'b0;
            r_vl       <= 1'b0;
            r_tag1     <= '0;
`ifdef LZD_NORM_EN
            r_a1       <= '0;
`endif
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_pu   <= w_pu;
                r_pl   <= w_pl;
                r_vu   <= w_vu;
                r_vl   <= w_vl;
                r_tag1 <= tag_in;
`ifdef LZD_NORM_EN
                r_a1   <= a;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_p         <= '0;
            r_v         <= 1'b0;
            r_tag_out   <= '0;
`ifdef LZD_NORM_EN
            r_norm      <= '0;
`endif
        end else if (!w_stall) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_p       <= w_p;
                r_v       <= w_v;
                r_tag_out <= r_tag1;
`ifdef LZD_NORM_EN
                r_norm    <= w_norm;
`endif
            end
        end
    end

endmodule
